// File: rtl/cm3_log.sv
// cm3_log: AHB-Lite slave that accumulates float32 energy samples into an
// unsigned Q32.32 accumulator and returns a Mitchell log2 of the sum as Q16.16.
module cm3_log (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic        hready_i,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready_o,
  output logic        hresp
);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrCtrl   = 2'd1;
  localparam logic [1:0] AddrResult = 2'd2;

  logic        r_valid;
  logic        r_write;
  logic [1:0]  r_addr;
  logic [63:0] r_acc;
  logic [15:0] r_count;

  logic        w_accept;
  logic        w_wr_data;
  logic        w_wr_clear;
  logic        w_rd_result;
  logic [7:0]  w_exp;
  logic [63:0] w_mant;
  logic [63:0] w_conv;
  logic [64:0] w_sum;
  logic [5:0]  w_p;
  logic [63:0] w_norm;
  logic [15:0] w_int;
  logic [31:0] w_log;

  assign hready_o = 1'b1;
  assign hresp    = 1'b0;

  assign w_accept    = hsel & hready_i & htrans[1];
  assign w_wr_data   = r_valid & r_write & (r_addr == AddrData);
  assign w_wr_clear  = r_valid & r_write & (r_addr == AddrCtrl) & hwdata[0];
  assign w_rd_result = r_valid & ~r_write & (r_addr == AddrResult);

  // Address-phase capture; a data phase lasts exactly one cycle (no wait states).
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 2'd0;
    end else begin
      r_valid <= w_accept;
      r_write <= hwrite;
      r_addr  <= haddr[3:2];
    end
  end

  // Float32 magnitude to Q32.32: {1,mant} scaled by 2^(e-118), saturating above 2^32.
  always_comb begin
    w_exp  = hwdata[30:23];
    w_mant = {40'd0, 1'b1, hwdata[22:0]};
    w_conv = 64'd0;
    if (w_exp == 8'd0) begin
      w_conv = 64'd0;
    end else if (w_exp >= 8'd159) begin
      w_conv = {64{1'b1}};
    end else if (w_exp >= 8'd118) begin
      w_conv = w_mant << (w_exp - 8'd118);
    end else begin
      w_conv = w_mant >> (8'd118 - w_exp);
    end
  end

  assign w_sum = {1'b0, r_acc} + {1'b0, w_conv};

  // Accumulator and sample count; clear by CTRL write or by RESULT read.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 64'd0;
      r_count <= 16'd0;
    end else if (w_wr_clear || w_rd_result) begin
      r_acc   <= 64'd0;
      r_count <= 16'd0;
    end else if (w_wr_data) begin
      r_acc   <= w_sum[64] ? {64{1'b1}} : w_sum[63:0];
      r_count <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    end
  end

  // Mitchell log2: leading-one index gives the integer part, the bits below it the fraction.
  always_comb begin
    w_p = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (r_acc[i]) w_p = 6'(i);
    end
    w_norm = r_acc << (6'd63 - w_p);
    w_int  = {10'd0, w_p} - 16'd32;
    w_log  = (r_acc == 64'd0) ? 32'h8000_0000 : {w_int, w_norm[62:47]};
  end

  // Read data mux, driven only during a valid read data phase.
  always_comb begin
    hrdata = 32'd0;
    if (r_valid && !r_write) begin
      unique case (r_addr)
        AddrCtrl:   hrdata = {16'd0, r_count};
        AddrResult: hrdata = w_log;
        default:    hrdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cm3_log.sv
// tb_cm3_log: table-driven directed test of cm3_log plus pipelined and reset corner cases.
module tb_cm3_log;

  logic        hclk;
  logic        rst_n;
  logic        hsel;
  logic        hready_i;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready_o;
  logic        hresp;

  int checks   = 0;
  int failures = 0;
  bit bad_const = 1'b0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs[$];

  cm3_log dut (
    .hclk     (hclk),
    .rst_n    (rst_n),
    .hsel     (hsel),
    .hready_i (hready_i),
    .hwrite   (hwrite),
    .htrans   (htrans),
    .haddr    (haddr),
    .hwdata   (hwdata),
    .hrdata   (hrdata),
    .hready_o (hready_o),
    .hresp    (hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // hready_o and hresp are constants; flag any deviation, checked once at the end.
  always @(negedge hclk) begin
    if (hready_o !== 1'b1 || hresp !== 1'b0) bad_const = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data;
    vecs.push_back(v);
  endtask

  task automatic set_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'd0;
  endtask

  // Single non-pipelined transfer: address phase, then data phase; returns hrdata.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr;
    @(posedge hclk); #1;
    set_idle();
    hwdata = wr ? wdata : 32'hDEAD_BEEF;
    rdata  = hrdata;
  endtask

  logic [31:0] rd;

  initial begin
    rst_n = 1'b0; hready_i = 1'b1; hwdata = 32'd0;
    set_idle();

    // Directed vector table.
    for (int i = 0; i < 10; i++) push(1, 32'h00, 32'h3F00_0000);
    push(0, 32'h04, 32'h0000_000A);
    push(0, 32'h08, 32'h0002_4000);
    for (int i = 0; i < 10; i++) push(1, 32'h00, 32'h3F00_0000);
    push(0, 32'h08, 32'h0002_4000);
    push(0, 32'h04, 32'h0000_0000);
    push(0, 32'h08, 32'h8000_0000);
    push(1, 32'h00, 32'h3F80_0000);
    push(0, 32'h08, 32'h0000_0000);
    push(1, 32'h00, 32'h7F80_0000);
    push(1, 32'h00, 32'h3F80_0000);
    push(0, 32'h08, 32'h001F_FFFF);
    push(1, 32'h00, 32'h4080_0000);
    push(1, 32'h04, 32'h0000_0001);
    push(1, 32'h00, 32'h4000_0000);
    push(0, 32'h08, 32'h0001_0000);
    push(1, 32'h00, 32'hC000_0000);
    push(0, 32'h08, 32'h0001_0000);
    push(0, 32'h00, 32'h0000_0000);
    push(0, 32'h0C, 32'h0000_0000);
    push(1, 32'h00, 32'h3F80_0000);
    push(1, 32'h08, 32'h1234_5678);  // RESULT write is ignored
    push(1, 32'h04, 32'h0000_0000);  // CTRL bit0=0 does not clear
    push(0, 32'h04, 32'h0000_0001);
    push(0, 32'h08, 32'h0000_0000);
    push(1, 32'h00, 32'h0000_0001);  // denormal contributes 0
    push(0, 32'h08, 32'h8000_0000);
    push(1, 32'h00, 32'h3380_0000);  // 2^-24 -> acc = 2^8
    push(0, 32'h08, 32'hFFE8_0000);
    push(1, 32'h00, 32'h4F00_0000);  // 2^31, largest finite shift
    push(0, 32'h08, 32'h001F_0000);
    push(1, 32'h00, 32'h4F80_0000);  // 2^32 saturates contribution
    push(0, 32'h08, 32'h001F_FFFF);

    repeat (2) @(posedge hclk);
    #1;
    check("reset_hrdata", hrdata, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, rd);
      if (!vecs[i].wr) check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr[7:0]), rd, vecs[i].data);
    end

    // Back-to-back pipelined: three 1.0 writes, then COUNT and RESULT reads.
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h00;
    @(posedge hclk); #1;
    htrans = 2'b11; hwdata = 32'h3F80_0000;
    @(posedge hclk); #1;
    hwdata = 32'h3F80_0000;
    @(posedge hclk); #1;
    hwrite = 1'b0; haddr = 32'h04; hwdata = 32'h3F80_0000;
    @(posedge hclk); #1;
    haddr = 32'h08; hwdata = 32'h0;
    check("pipe_count", hrdata, 32'h0000_0003);
    @(posedge hclk); #1;
    set_idle();
    check("pipe_result", hrdata, 32'h0001_8000);
    @(posedge hclk); #1;
    check("idle_hrdata", hrdata, 32'h0);
    xfer(0, 32'h04, 32'h0, rd);
    check("pipe_cleared", rd, 32'h0);

    // Reset during a DATA write data phase aborts it.
    xfer(1, 32'h00, 32'h3F80_0000, rd);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h00;
    @(posedge hclk); #1;
    set_idle();
    hwdata = 32'h4000_0000;
    rst_n = 1'b0;
    #1;
    check("rst_hrdata", hrdata, 32'h0);
    @(posedge hclk); #1;
    rst_n = 1'b1;
    xfer(0, 32'h04, 32'h0, rd);
    check("rst_count", rd, 32'h0);
    xfer(0, 32'h08, 32'h0, rd);
    check("rst_result", rd, 32'h8000_0000);

    @(posedge hclk); #1;
    check("hready_hresp_const", {31'd0, bad_const}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
